// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - sequenced release of NUM_STAGES downstream reset domains
//
// Purpose: after sreset, and while en (PLL lock) is high, releases stage resets one
// at a time. Each stage is held STAGE_DELAY cycles, then released, and must ack
// before the next stage starts. A soft_req pulse re-runs the whole sequence.
//
// Optional feature: define RESET_SEQ_TIMEOUT_EN to enable the ack timeout.
//   When defined, a stage that does not ack within ACK_TIMEOUT cycles puts the
//   block into a sticky FAULT state: all stage resets are reasserted and fault is
//   set. When not defined, the block waits for acks indefinitely and fault and
//   fault_stage are tied low.
//
// Ports:
//   clk          in   system clock
//   sreset       in   synchronous reset, active-high
//   en           in   enable / PLL lock; low forces all stage resets
//   soft_req     in   single-cycle request to re-run the sequence
//   stage_ack    in   per-stage ready; only the bit of the current stage is used
//   stage_reset  out  per-stage reset, active-high, registered
//   all_ready    out  all stages released and acked, registered
//   fault        out  sticky ack-timeout flag
//   fault_stage  out  index of the stage that timed out
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          sreset,
    input  logic                          en,
    input  logic                          soft_req,
    input  logic [NUM_STAGES-1:0]         stage_ack,
    output logic [NUM_STAGES-1:0]         stage_reset,
    output logic                          all_ready,
    output logic                          fault,
    output logic [$clog2(NUM_STAGES)-1:0] fault_stage
);

    localparam int IW   = $clog2(NUM_STAGES);
    localparam int CMAX = (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX);

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_STAGES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(STAGE_DELAY - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_DELAY,
        S_WAIT_ACK,
        S_RUN,
        S_FAULT
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   ctr;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

    logic            fault_q;
    logic [IW-1:0]   fault_stage_q;

    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;
`else
    assign fault       = 1'b0;
    assign fault_stage = '0;
`endif

    always_ff @(posedge clk) begin
        if (sreset) begin
            state       <= S_HOLD;
            idx         <= '0;
            ctr         <= '0;
            stage_reset <= '1;
            all_ready   <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
`endif
        end else if (!en) begin
            // Losing lock restarts everything except a latched fault, which
            // must be cleared explicitly with soft_req.
            if (state != S_FAULT) begin
                state       <= S_HOLD;
                idx         <= '0;
                ctr         <= '0;
                stage_reset <= '1;
                all_ready   <= 1'b0;
            end
        end else if (soft_req && (state != S_HOLD)) begin
            state       <= S_HOLD;
            idx         <= '0;
            ctr         <= '0;
            stage_reset <= '1;
            all_ready   <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
`endif
        end else begin
            case (state)
                S_HOLD: begin
                    state <= S_DELAY;
                    idx   <= '0;
                    ctr   <= '0;
                end
                S_DELAY: begin
                    if (ctr == DELAY_LAST) begin
                        stage_reset[idx] <= 1'b0;
                        ctr              <= '0;
                        state            <= S_WAIT_ACK;
                    end else begin
                        ctr <= ctr + CW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    // Ack is checked before the timeout so a same-edge ack wins.
                    if (stage_ack[idx]) begin
                        ctr <= '0;
                        if (idx == LAST_IDX) begin
                            state     <= S_RUN;
                            all_ready <= 1'b1;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_DELAY;
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else if (ctr == ACK_LAST) begin
                        state         <= S_FAULT;
                        fault_q       <= 1'b1;
                        fault_stage_q <= idx;
                        stage_reset   <= '1;
                        ctr           <= '0;
                    end else begin
                        ctr <= ctr + CW'(1);
                    end
`endif
                end
                S_RUN: begin
                    all_ready <= 1'b1;
                end
                S_FAULT: begin
                    stage_reset <= '1;
                    all_ready   <= 1'b0;
                end
                default: begin
                    state       <= S_HOLD;
                    idx         <= '0;
                    ctr         <= '0;
                    stage_reset <= '1;
                    all_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int NS = 3;
    localparam int SD = 4;
    localparam int AT = 8;

    logic          clk;
    logic          sreset;
    logic          en;
    logic          soft_req;
    logic [NS-1:0] stage_ack;
    logic [NS-1:0] stage_reset;
    logic          all_ready;
    logic          fault;
    logic [1:0]    fault_stage;

    int tests;
    int failed;

    reset_sequencer #(
        .NUM_STAGES (NS),
        .STAGE_DELAY(SD),
        .ACK_TIMEOUT(AT)
    ) dut (
        .clk        (clk),
        .sreset     (sreset),
        .en         (en),
        .soft_req   (soft_req),
        .stage_ack  (stage_ack),
        .stage_reset(stage_reset),
        .all_ready  (all_ready),
        .fault      (fault),
        .fault_stage(fault_stage)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds sreset for two edges; the next posedge after return is edge 1.
    task automatic do_reset(input logic [NS-1:0] ack);
        sreset    = 1'b1;
        en        = 1'b1;
        soft_req  = 1'b0;
        stage_ack = ack;
        tick(2);
        sreset = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        sreset = 1'b1; en = 1'b0; soft_req = 1'b0; stage_ack = '0;

        // Normal sequence with immediate acks
        do_reset(3'b111);
        chk("rst_stage_reset", stage_reset, 3'b111);
        chk("rst_all_ready", all_ready, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_fault_stage", fault_stage, 2'd0);
        tick(4);   // edge 4
        chk("t1_e4", stage_reset, 3'b111);
        tick(1);   // edge 5
        chk("t1_e5", stage_reset, 3'b110);
        tick(4);   // edge 9
        chk("t1_e9", stage_reset, 3'b110);
        tick(1);   // edge 10
        chk("t1_e10", stage_reset, 3'b100);
        tick(5);   // edge 15
        chk("t1_e15", stage_reset, 3'b000);
        chk("t1_e15_ready", all_ready, 1'b0);
        tick(1);   // edge 16
        chk("t1_e16_ready", all_ready, 1'b1);
        chk("t1_e16_fault", fault, 1'b0);
        stage_ack = 3'b000;
        tick(3);
        chk("t1_run_ignores_ack", all_ready, 1'b1);

        // Soft re-sequence from RUN
        stage_ack = 3'b111;
        soft_req  = 1'b1;
        tick(1);   // edge S
        soft_req = 1'b0;
        chk("t3_sr", stage_reset, 3'b111);
        chk("t3_ready_low", all_ready, 1'b0);
        tick(15);  // S+15
        chk("t3_s15_ready", all_ready, 1'b0);
        tick(1);   // S+16
        chk("t3_s16_ready", all_ready, 1'b1);
        chk("t3_s16_sr", stage_reset, 3'b000);

        // en drop with soft_req mid-DELAY of stage 1
        do_reset(3'b111);
        tick(7);   // edge 7
        chk("t4_e7", stage_reset, 3'b110);
        en = 1'b0; soft_req = 1'b1;
        tick(1);   // edge 8
        chk("t4_e8", stage_reset, 3'b111);
        chk("t4_e8_ready", all_ready, 1'b0);
        en = 1'b1; soft_req = 1'b0;
        tick(4);   // edge 12
        chk("t4_e12", stage_reset, 3'b111);
        tick(1);   // edge 13
        chk("t4_e13", stage_reset, 3'b110);

`ifdef RESET_SEQ_TIMEOUT_EN
        // Stage 1 never acks -> timeout
        do_reset(3'b101);
        tick(10);  // edge 10
        chk("t2_e10", stage_reset, 3'b100);
        tick(7);   // edge 17
        chk("t2_e17_fault", fault, 1'b0);
        tick(1);   // edge 18
        chk("t2_e18_fault", fault, 1'b1);
        chk("t2_e18_stage", fault_stage, 2'd1);
        chk("t2_e18_sr", stage_reset, 3'b111);
        chk("t2_e18_ready", all_ready, 1'b0);
        en = 1'b0;
        tick(1);
        chk("t2_en_low_keeps_fault", fault, 1'b1);
        en = 1'b1; soft_req = 1'b1; stage_ack = 3'b111;
        tick(1);   // edge S
        soft_req = 1'b0;
        chk("t2_clear_fault", fault, 1'b0);
        chk("t2_clear_stage", fault_stage, 2'd0);
        tick(16);
        chk("t2_rerun_ready", all_ready, 1'b1);
        chk("t2_rerun_sr", stage_reset, 3'b000);

        // Ack arrives exactly on the timeout edge
        do_reset(3'b000);
        tick(12);  // edge 12, ctr==7
        chk("t5_e12_sr", stage_reset, 3'b110);
        chk("t5_e12_fault", fault, 1'b0);
        stage_ack = 3'b001;
        tick(1);   // edge 13
        chk("t5_e13_fault", fault, 1'b0);
        stage_ack = 3'b000;
        tick(3);   // edge 16
        chk("t5_e16_sr", stage_reset, 3'b110);
        tick(1);   // edge 17
        chk("t5_e17_sr", stage_reset, 3'b100);
        chk("t5_e17_fault", fault, 1'b0);
`else
        // No timeout: stage 0 waits indefinitely
        do_reset(3'b000);
        tick(200);
        chk("t6_fault", fault, 1'b0);
        chk("t6_fault_stage", fault_stage, 2'd0);
        chk("t6_sr", stage_reset, 3'b110);
        chk("t6_ready", all_ready, 1'b0);
        stage_ack = 3'b001;
        tick(1);   // edge 201
        stage_ack = 3'b000;
        tick(3);   // edge 204
        chk("t6_e204", stage_reset, 3'b110);
        tick(1);   // edge 205
        chk("t6_e205", stage_reset, 3'b100);
        chk("t6_e205_fault", fault, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
